// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies the synchronised
// lock flag, holds downstream logic in reset until lock is stable, retries on
// lock timeout and latches a fault after repeated failures. Runs entirely on
// the PLL reference clock so it never depends on the clock it supervises.
module pll_lock_supervisor #(
    parameter int RESET_PULSE  = 16,
    parameter int LOCK_TIMEOUT = 4800,
    parameter int LOCK_STABLE  = 480,
    parameter int MAX_RETRIES  = 3
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       locked,
    input  logic       rearm,
    output logic       pll_resetb,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    // Terminal timer values: each phase ends on the cycle the timer hits N-1.
    localparam logic [15:0] RP_LAST = 16'(RESET_PULSE - 1);
    localparam logic [15:0] TO_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] ST_LAST = 16'(LOCK_STABLE - 1);
    localparam logic [3:0]  MAXR    = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [1:0]  sync_q;
    logic [3:0]  retry_q, retry_d;
    logic [7:0]  llc_q, llc_d;
    logic        pll_resetb_q, pll_resetb_d;
    logic        sys_reset_q, sys_reset_d;
    logic        ready_q, ready_d;
    logic        fault_q, fault_d;
    logic        lock_s;

    assign lock_s = sync_q[1];

    // Two-flop synchroniser for the asynchronous PLL locked flag.
    always_ff @(posedge clock_in) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], locked};
    end

    // Next-state, counter updates and output decode from the next state.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        llc_d   = llc_q;
        unique case (state_q)
            PLL_RESET: begin
                if (timer_q == RP_LAST) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABILIZE;
                end else if (timer_q == TO_LAST) begin
                    if (retry_q == MAXR) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 4'd1;
                        state_d = PLL_RESET;
                    end
                end
            end
            STABILIZE: begin
                // A dropout restarts the lock wait without consuming a retry.
                if (!lock_s)                  state_d = WAIT_LOCK;
                else if (timer_q == ST_LAST)  state_d = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    if (llc_q != 8'hFF) llc_d = llc_q + 8'd1;
                    state_d = PLL_RESET;
                end
            end
            FAULT: begin
                if (rearm) begin
                    retry_d = 4'd0;
                    state_d = PLL_RESET;
                end
            end
            default: state_d = PLL_RESET;
        endcase

        // A successful lock forgives earlier timeouts.
        if (state_d == RUN && state_q != RUN) retry_d = 4'd0;

        // Shared timer restarts on any state change; it holds at full scale
        // in RUN/FAULT where it is not compared.
        if (state_d != state_q)     timer_d = 16'd0;
        else if (timer_q == 16'hFFFF) timer_d = timer_q;
        else                        timer_d = timer_q + 16'd1;

        pll_resetb_d = !(state_d == PLL_RESET || state_d == FAULT);
        sys_reset_d  = (state_d != RUN);
        ready_d      = (state_d == RUN);
        fault_d      = (state_d == FAULT);
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q      <= PLL_RESET;
            timer_q      <= 16'd0;
            retry_q      <= 4'd0;
            llc_q        <= 8'd0;
            pll_resetb_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            retry_q      <= retry_d;
            llc_q        <= llc_d;
            pll_resetb_q <= pll_resetb_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = llc_q;

endmodule
